// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory-side responder.
package mem_resp_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latency counter width; covers LATENCY values 1..15.
    localparam int LAT_CNT_W = 4;

    // Width of the completed-response statistics counter.
    localparam int RESP_CNT_W = 16;

    // Word returned for out-of-range addresses (RV32 NOP: addi x0, x0, 0).
    localparam logic [31:0] DEFAULT_OOR_WORD = 32'h0000_0013;

endpackage

// File: rtl/mem_resp_array.sv
// Preloadable word array: one synchronous write port, one asynchronous read port.
module mem_resp_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Preload write port.
    // NOTE: the array has no reset; contents survive resetn and are only changed by writes.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read; a same-edge write is seen only after that edge.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts single-word requests, snapshots the word at
// acceptance and returns it with a registered one-cycle ready strobe after LATENCY edges.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter int                    LATENCY    = 4,
    parameter logic [DATA_WIDTH-1:0] OOR_WORD   = DATA_WIDTH'(DEFAULT_OOR_WORD)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_rdata,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy,
    output logic                  oor_err,
    output logic [RESP_CNT_W-1:0] resp_count
);

    // WAIT is entered with LATENCY-2 so RESP is reached LATENCY-1 edges after acceptance.
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

    state_e                  state_q, state_d;
    logic [LAT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   snap_q, snap_d;
    logic                    snap_oor_q, snap_oor_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    oor_q, oor_d;
    logic                    busy_q, busy_d;
    logic [RESP_CNT_W-1:0]   resp_count_q, resp_count_d;

    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    addr_oor;
    logic [DATA_WIDTH-1:0]   array_rdata;
    logic                    unused_addr_lsb;

    assign word_idx        = mem_req_addr[DEPTH_LOG2+1:2];
    assign addr_oor        = |mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign unused_addr_lsb = ^mem_req_addr[1:0];

    mem_resp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (word_idx),
        .rdata_o (array_rdata)
    );

    // Next-state, snapshot capture and registered-output inputs.
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        snap_oor_d   = snap_oor_q;
        rdata_d      = rdata_q;
        resp_count_d = resp_count_q;

        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    snap_d     = addr_oor ? OOR_WORD : array_rdata;
                    snap_oor_d = addr_oor;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Entering RESP publishes the snapshot and counts the response.
        if ((state_d == RESP) && (state_q != RESP)) begin
            rdata_d      = snap_d;
            resp_count_d = resp_count_q + RESP_CNT_W'(1);
        end

        ready_d = (state_q == RESP);
        oor_d   = (state_q == RESP) && snap_oor_q;
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; asynchronous reset aborts any in-flight request.
    // NOTE: non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            snap_q       <= '0;
            snap_oor_q   <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            oor_q        <= 1'b0;
            busy_q       <= 1'b0;
            resp_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            snap_oor_q   <= snap_oor_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            oor_q        <= oor_d;
            busy_q       <= busy_d;
            resp_count_q <= resp_count_d;
        end
    end

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;
    assign oor_err       = oor_q;
    assign busy          = busy_q;
    assign resp_count    = resp_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid4, valid1;
    logic [31:0] addr;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic        rdy4, rdy1, busy4, busy1, oor4, oor1;
    logic [31:0] rdata4, rdata1;
    logic [15:0] cnt4, cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(4)) dut4 (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req_valid (valid4),
        .mem_req_ready (rdy4),
        .mem_req_addr  (addr),
        .mem_req_rdata (rdata4),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .busy          (busy4),
        .oor_err       (oor4),
        .resp_count    (cnt4)
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req_valid (valid1),
        .mem_req_ready (rdy1),
        .mem_req_addr  (addr),
        .mem_req_rdata (rdata1),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .busy          (busy1),
        .oor_err       (oor1),
        .resp_count    (cnt1)
    );

    // Preload one word; called 1 time unit after a rising edge.
    task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Counts rising edges from now until dut4 ready is seen (n=0 on timeout), then drops valid.
    task automatic wait_ready4(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rdy4) begin
                n = i;
                break;
            end
        end
        valid4 = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (rdy4 !== 1'b0)    begin errors++; $display("FAIL reset_ready4: got %b expected 0", rdy4); end
        checks++; if (rdata4 !== 32'h0) begin errors++; $display("FAIL reset_rdata4: got %h expected 0", rdata4); end
        checks++; if (oor4 !== 1'b0)    begin errors++; $display("FAIL reset_oor4: got %b expected 0", oor4); end
        checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        checks++; if (cnt4 !== 16'h0)   begin errors++; $display("FAIL reset_count4: got %h expected 0", cnt4); end
        checks++; if (rdy1 !== 1'b0)    begin errors++; $display("FAIL reset_ready1: got %b expected 0", rdy1); end
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL idle_busy4: got %b expected 0", busy4); end
    endtask

    task automatic test_basic_read;
        int n;
        addr   = 32'h0;
        valid4 = 1'b1;
        wait_ready4(n);
        // Acceptance edge plus LATENCY=4 edges.
        checks++; if (n !== 5)               begin errors++; $display("FAIL basic_latency: got %0d expected 5", n); end
        checks++; if (rdata4 !== 32'h2202)   begin errors++; $display("FAIL basic_rdata: got %h expected 00002202", rdata4); end
        checks++; if (oor4 !== 1'b0)         begin errors++; $display("FAIL basic_oor: got %b expected 0", oor4); end
        checks++; if (cnt4 !== 16'd1)        begin errors++; $display("FAIL basic_count: got %0d expected 1", cnt4); end
        @(posedge clk); #1;
        checks++; if (rdy4 !== 1'b0)         begin errors++; $display("FAIL basic_ready_width: got %b expected 0", rdy4); end
        checks++; if (rdata4 !== 32'h2202)   begin errors++; $display("FAIL basic_rdata_hold: got %h expected 00002202", rdata4); end
        checks++; if (busy4 !== 1'b0)        begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy4); end
    endtask

    task automatic test_out_of_range;
        int n;
        addr   = 32'h0000_0400;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (n !== 5)               begin errors++; $display("FAIL oor_latency: got %0d expected 5", n); end
        checks++; if (rdata4 !== 32'h13)     begin errors++; $display("FAIL oor_rdata: got %h expected 00000013", rdata4); end
        checks++; if (oor4 !== 1'b1)         begin errors++; $display("FAIL oor_flag: got %b expected 1", oor4); end
        checks++; if (cnt4 !== 16'd2)        begin errors++; $display("FAIL oor_count: got %0d expected 2", cnt4); end
        @(posedge clk); #1;
        checks++; if (oor4 !== 1'b0)         begin errors++; $display("FAIL oor_flag_clear: got %b expected 0", oor4); end
        addr   = 32'h0;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (oor4 !== 1'b0)         begin errors++; $display("FAIL inrange_oor: got %b expected 0", oor4); end
        checks++; if (rdata4 !== 32'h2202)   begin errors++; $display("FAIL inrange_rdata: got %h expected 00002202", rdata4); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_hazard;
        int n;
        addr      = 32'h14;
        valid4    = 1'b1;
        load_en   = 1'b1;
        load_addr = 8'd5;
        load_data = 32'h2222_2222;
        @(posedge clk); #1;           // acceptance edge, same-edge write
        valid4 = 1'b0;
        checks++; if (busy4 !== 1'b1)          begin errors++; $display("FAIL hazard_busy: got %b expected 1", busy4); end
        @(posedge clk); #1;           // second write lands during WAIT
        load_en = 1'b0;
        wait_ready4(n);
        checks++; if (n !== 3)                 begin errors++; $display("FAIL hazard_latency: got %0d expected 3", n); end
        checks++; if (rdata4 !== 32'h1111_1111) begin errors++; $display("FAIL hazard_rdata: got %h expected 11111111", rdata4); end
        checks++; if (cnt4 !== 16'd4)          begin errors++; $display("FAIL hazard_count: got %0d expected 4", cnt4); end
        @(posedge clk); #1;
        addr   = 32'h14;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (rdata4 !== 32'h2222_2222) begin errors++; $display("FAIL hazard_reread: got %h expected 22222222", rdata4); end
        checks++; if (cnt4 !== 16'd5)          begin errors++; $display("FAIL hazard_count2: got %0d expected 5", cnt4); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait;
        int n;
        int pulses;
        addr   = 32'h0;
        valid4 = 1'b1;
        @(posedge clk); #1;
        valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b1)   begin errors++; $display("FAIL midwait_busy: got %b expected 1", busy4); end
        checks++; if (rdy4 !== 1'b0)    begin errors++; $display("FAIL midwait_ready: got %b expected 0", rdy4); end
        resetn = 1'b0;
        #1;
        checks++; if (rdy4 !== 1'b0)    begin errors++; $display("FAIL abort_ready: got %b expected 0", rdy4); end
        checks++; if (rdata4 !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rdata4); end
        checks++; if (oor4 !== 1'b0)    begin errors++; $display("FAIL abort_oor: got %b expected 0", oor4); end
        checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b expected 0", busy4); end
        checks++; if (cnt4 !== 16'h0)   begin errors++; $display("FAIL abort_count: got %0d expected 0", cnt4); end
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rdy4) pulses++;
        end
        checks++; if (pulses !== 0)     begin errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", pulses); end
        addr   = 32'h4;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (n !== 5)                  begin errors++; $display("FAIL postreset_latency: got %0d expected 5", n); end
        checks++; if (rdata4 !== 32'hAAAA_0001) begin errors++; $display("FAIL postreset_rdata: got %h expected AAAA0001", rdata4); end
        checks++; if (cnt4 !== 16'd1)           begin errors++; $display("FAIL postreset_count: got %0d expected 1", cnt4); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        addr   = 32'h4;
        valid1 = 1'b1;
        @(posedge clk); #1;           // first acceptance, straight to RESP
        checks++; if (rdy1 !== 1'b0)            begin errors++; $display("FAIL b2b_ready_e0: got %b expected 0", rdy1); end
        checks++; if (busy1 !== 1'b1)           begin errors++; $display("FAIL b2b_busy_e0: got %b expected 1", busy1); end
        @(posedge clk); #1;
        checks++; if (rdy1 !== 1'b1)            begin errors++; $display("FAIL b2b_ready_1: got %b expected 1", rdy1); end
        checks++; if (rdata1 !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_rdata_1: got %h expected AAAA0001", rdata1); end
        checks++; if (cnt1 !== 16'd1)           begin errors++; $display("FAIL b2b_count_1: got %0d expected 1", cnt1); end
        addr = 32'h8;                 // valid stays high: new request at this edge
        @(posedge clk); #1;
        checks++; if (rdy1 !== 1'b0)            begin errors++; $display("FAIL b2b_ready_gap: got %b expected 0", rdy1); end
        @(posedge clk); #1;
        checks++; if (rdy1 !== 1'b1)            begin errors++; $display("FAIL b2b_ready_2: got %b expected 1", rdy1); end
        checks++; if (rdata1 !== 32'hAAAA_0002) begin errors++; $display("FAIL b2b_rdata_2: got %h expected AAAA0002", rdata1); end
        checks++; if (cnt1 !== 16'd2)           begin errors++; $display("FAIL b2b_count_2: got %0d expected 2", cnt1); end
        valid1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy1 !== 1'b0)            begin errors++; $display("FAIL b2b_ready_end: got %b expected 0", rdy1); end
        checks++; if (busy1 !== 1'b0)           begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy1); end
    endtask

    task automatic test_count_wrap;
        int n;
        force dut4.resp_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut4.resp_count_q;
        addr   = 32'h0;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (cnt4 !== 16'h0)         begin errors++; $display("FAIL wrap_count: got %h expected 0000", cnt4); end
        checks++; if (rdata4 !== 32'h2202)    begin errors++; $display("FAIL wrap_rdata: got %h expected 00002202", rdata4); end
        @(posedge clk); #1;
        valid4 = 1'b1;
        wait_ready4(n);
        checks++; if (cnt4 !== 16'h1)         begin errors++; $display("FAIL wrap_count_next: got %h expected 0001", cnt4); end
    endtask

    initial begin
        resetn    = 1'b0;
        valid4    = 1'b0;
        valid1    = 1'b0;
        addr      = 32'h0;
        load_en   = 1'b0;
        load_addr = 8'h0;
        load_data = 32'h0;
        test_reset;
        load_word(8'd0, 32'h0000_2202);
        load_word(8'd1, 32'hAAAA_0001);
        load_word(8'd2, 32'hAAAA_0002);
        load_word(8'd5, 32'h1111_1111);
        test_basic_read;
        test_out_of_range;
        test_load_hazard;
        test_reset_mid_wait;
        test_back_to_back;
        test_count_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
